mem_model_4c: RTL
=================

# mem_model_4c

Word-addressed main-memory responder that answers the cache fill FSM and data-cache store path. It accepts one request per cycle: writes commit immediately, reads return data exactly `LATENCY` cycles later with a valid strobe. Reads are fully pipelined, so an 8-word cache-line fill issued back-to-back returns 8 consecutive valid words. It replaces the ad-hoc delay and shift logic in benches and is the memory endpoint at the system top level.

## Interface
- `LATENCY`, 4: read latency in cycles, from request accept to `data_valid`; legal range 1–8.
- `ADDR_W`, 16: byte-address width.
- `DEPTH`, 32768: number of 16-bit words stored; index is `addr[ADDR_W-1:1]`.
- `INIT_FILE`, "": hex image loaded into the array at time 0 when non-empty.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  request strobe; one request is accepted per cycle while high.
- `wr`  in  1  1 = write request, 0 = read request; ignored when `enable` = 0.
- `addr`  in  ADDR_W  byte address; bit 0 ignored.
- `data_in`  in  16  write data.
- `data_out`  out  16  read data; meaningful only while `data_valid` = 1, 0x0000 otherwise.
- `data_valid`  out  1  read data returned this cycle.
- `busy`  out  1  one or more reads in flight (not yet returned).
- `rd_inflight`  out  4  number of reads in flight, 0..LATENCY.

## Operation
- Write (`enable`=1, `wr`=1): `mem[addr[ADDR_W-1:1]] <= data_in` at the edge. No response strobe. Does not enter the read pipeline.
- Read (`enable`=1, `wr`=0): the array is sampled at the accept edge into stage 1 of a LATENCY-deep pipeline of {valid, data}. Stage k advances to stage k+1 each cycle. The last stage drives `data_out` and `data_valid`.
- The read value is captured at issue. A write accepted in a later cycle does not alter a read already in flight.
- Write then read to the same address in the next cycle returns the new data.
- Unaccepted cycles (`enable`=0) inject a bubble (valid=0).
- No backpressure: the pipeline never stalls, and the requester must accept every `data_valid` cycle.
- `rd_inflight` increments on a read accept and decrements on a `data_valid` cycle. When both happen in the same cycle the count is unchanged. `busy` = (`rd_inflight` != 0).
- Addresses wrap modulo DEPTH. The array is not cleared by reset.

## Timing
- Reset (async assert, sync release behaviour on edges):
  - All pipeline valid bits clear, so `data_valid`=0.
  - `data_out`=0x0000, `rd_inflight`=0, `busy`=0.
  - In-flight reads are discarded.
  - The array contents are retained.
- Read accepted at edge N: `data_valid`=1 and `data_out` valid in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- With LATENCY=4, a request in cycle 0 returns data in cycle 4.
- Back-to-back reads in cycles 0..7 give `data_valid` high in cycles 4..11 with no gaps, and `data_out` in issue order.
- Interleaved write at cycle t: no effect on `data_valid` timing of surrounding reads.
- Reset asserted mid-burst: outputs clear immediately (asynchronously). Requests are honoured again from the first edge after release.

## Structure
- Shared package `mem_pkg`:
  - `MEM_LATENCY` = 4
  - `word_t` (16-bit)
  - `mem_req_t` struct {enable, wr, addr, data}
- Sub-module `delay_pipe`: parameterized LATENCY × (1+16) shift register with asynchronous clear of the valid bits. The top level owns the array, the write port and the in-flight counter.
- The array is a behavioural `reg` memory. It is loaded via `$readmemh` when INIT_FILE is non-empty.

## Test plan
- Reset checks:
  - Reset with `enable`=1: outputs 0, `busy`=0.
  - Release, then read 0x0000 of a zeroed array: `data_valid` after exactly 4 cycles, `data_out`=0x0000.
- Write 0xDEAD to 0x1234 in cycle 0, read 0x1234 in cycle 1 -> `data_valid`=1 in cycle 5 with 0xDEAD, `rd_inflight` 1 in cycles 2..5.
- Preload words 0x1111..0x8888 at 0x2230..0x223E:
  - Read 8 addresses back-to-back in cycles 0..7 -> valid in cycles 4..11, data 0x1111..0x8888 in order.
  - `rd_inflight` peaks at 4.
- Read 0x1375 in cycle 0, write 0xBEEF to 0x1375 in cycle 1 -> the cycle-4 return is the old value; a read in cycle 2 returns 0xBEEF in cycle 6.
- Issue 3 reads, assert `rst_n`=0 in cycle 2 -> `data_valid` never rises for them; after release, a new read returns normally 4 cycles later.
- Bubbles and boundary: read pattern with `enable` toggling 1,0,1,1 -> valid pattern 1,0,1,1 shifted by 4 cycles. Address 0xFFFE wraps to word index DEPTH-1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the word-addressed memory model and its clients.
package mem_pkg;

    localparam int unsigned MEM_LATENCY = 4;
    localparam int unsigned MEM_ADDR_W  = 16;

    typedef logic [15:0] word_t;

    typedef struct packed {
        logic                  enable;
        logic                  wr;
        logic [MEM_ADDR_W-1:0] addr;
        word_t                 data;
    } mem_req_t;

endpackage

// File: rtl/delay_pipe.sv
// Fixed-length {valid, data} shift register; only the valid bits are cleared by reset.
module delay_pipe #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [STAGES-1:0] valid_q;
    logic [W-1:0]      data_q [STAGES];

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // NOTE: the data payload is deliberately left out of reset; it is qualified by the
    // valid bits, and skipping reset keeps these as plain shift registers.
    always_ff @(posedge clk) begin
        data_q[0] <= data_i;
        for (int k = 1; k < STAGES; k++) begin
            data_q[k] <= data_q[k-1];
        end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/mem_model_4c.sv
// Main-memory responder: immediate writes, fully pipelined reads returning after LATENCY cycles.
module mem_model_4c
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY   = MEM_LATENCY,
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DEPTH     = 32768,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             data_in,
    output word_t             data_out,
    output logic              data_valid,
    output logic              busy,
    output logic [3:0]        rd_inflight
);

    // DEPTH is a power of two, so keeping only the low index bits wraps addresses.
    localparam int unsigned IDX_W = $clog2(DEPTH);

    mem_req_t         req;
    logic [IDX_W-1:0] idx;
    logic             rd_accept;
    word_t            rd_word;
    word_t            pipe_data;
    logic [3:0]       inflight_q, inflight_d;
    logic             unused_addr_lsb;

    assign req             = '{enable: enable, wr: wr, addr: MEM_ADDR_W'(addr), data: data_in};
    assign idx             = req.addr[IDX_W:1];
    assign unused_addr_lsb = req.addr[0];
    assign rd_accept       = req.enable && !req.wr;

    // Behavioural array; contents survive rst_n.
    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (req.enable && req.wr) mem[idx] <= req.data;
    end

    // Sampled at the accept edge, so later writes cannot disturb a read in flight.
    assign rd_word = mem[idx];

    delay_pipe #(
        .STAGES (LATENCY),
        .W      ($bits(word_t))
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (rd_accept),
        .data_i  (rd_word),
        .valid_o (data_valid),
        .data_o  (pipe_data)
    );

    assign data_out = data_valid ? pipe_data : '0;

    // NOTE: the default assignment first guarantees every path drives inflight_d,
    // so no latch is inferred.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({rd_accept, data_valid})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_q <= '0;
        else        inflight_q <= inflight_d;
    end

    assign rd_inflight = inflight_q;
    assign busy        = (inflight_q != 4'd0);

endmodule
